// File: rtl/ball_motion.sv
// Ball position integrator: decodes the 4-bit direction into per-axis velocity and advances x/y (Q13.8) once
// per motion tick, with wall clamping, goal re-centring and a serve hold. Optional macro: BALL_SPEEDUP_EN.
module ball_motion #(
   parameter int FIELD_W    = 2560,
   parameter int FIELD_H    = 1920,
   parameter int TICK_DIV   = 4,
   parameter int HOLD_TICKS = 60,
   parameter int SPEED_MAX  = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  direction,
   input  logic [12:0] move_speed,
   input  logic [12:0] size,
   input  logic        goal_p1,
   input  logic        goal_p2,
   output logic [12:0] x,
   output logic [12:0] y,
   output logic        moving,
   output logic        tick,
   output logic [12:0] cur_speed
);
   localparam int DIV_W  = $clog2(TICK_DIV);
   localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

   typedef enum logic [1:0] {HOLD, RUN, GOAL} state_t;

   state_t              state_reg, state_next;
   logic [DIV_W-1:0]    div_reg;
   logic [HOLD_W-1:0]   hold_reg, hold_next;
   logic [20:0]         px_reg, py_reg, px_next, py_next;
   logic signed [9:0]   cx, cy;
   logic signed [22:0]  prod_x, prod_y;
   logic signed [15:0]  x_hi, y_hi;
   logic                goal_any, step_en;

   // round(256*sin(d*22.5 deg)); the y component reuses it a quarter turn ahead
   function automatic logic signed [9:0] sin_lut(input logic [3:0] d);
      logic signed [9:0] v;
      case (d)
         4'd0:    v = 10'sd0;
         4'd1:    v = 10'sd98;
         4'd2:    v = 10'sd181;
         4'd3:    v = 10'sd237;
         4'd4:    v = 10'sd256;
         4'd5:    v = 10'sd237;
         4'd6:    v = 10'sd181;
         4'd7:    v = 10'sd98;
         4'd8:    v = 10'sd0;
         4'd9:    v = -10'sd98;
         4'd10:   v = -10'sd181;
         4'd11:   v = -10'sd237;
         4'd12:   v = -10'sd256;
         4'd13:   v = -10'sd237;
         4'd14:   v = -10'sd181;
         default: v = -10'sd98;
      endcase
      return v;
   endfunction

   // Add the velocity step and clamp the integer part onto [lo, hi]; negative sums clamp to lo
   function automatic logic [20:0] step_axis(input logic [20:0] pos, input logic signed [22:0] prod,
                                             input logic [12:0] lo, input logic signed [15:0] hi);
      logic signed [23:0] sum;
      logic signed [15:0] ipart;
      logic [20:0]        res;
      sum   = $signed({3'b000, pos}) + $signed({prod[22], prod});
      ipart = sum[23:8];
      if (ipart < $signed({3'b000, lo}))
         res = {lo, 8'h00};
      else if (ipart > hi)
         res = {hi[12:0], 8'h00};
      else
         res = sum[20:0];
      return res;
   endfunction

   assign cx       = sin_lut(direction);
   assign cy       = -sin_lut(direction + 4'd4);
   assign prod_x   = $signed({1'b0, cur_speed}) * cx;
   assign prod_y   = $signed({1'b0, cur_speed}) * cy;
   assign x_hi     = 16'(FIELD_W) - $signed({3'b000, size});
   assign y_hi     = 16'(FIELD_H) - $signed({3'b000, size});
   assign goal_any = goal_p1 | goal_p2;
   assign step_en  = (state_reg == RUN) && tick && !goal_any;

   assign tick   = (div_reg == DIV_W'(TICK_DIV - 1));
   assign moving = (state_reg == RUN);
   assign x      = px_reg[20:8];
   assign y      = py_reg[20:8];

   always_ff @(posedge clk) begin
      if (rst) begin
         div_reg   <= '0;
         state_reg <= HOLD;
         hold_reg  <= '0;
         px_reg    <= {13'(FIELD_W / 2), 8'h00};
         py_reg    <= {13'(FIELD_H / 2), 8'h00};
      end else begin
         div_reg   <= tick ? '0 : div_reg + 1'b1;
         state_reg <= state_next;
         hold_reg  <= hold_next;
         px_reg    <= px_next;
         py_reg    <= py_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      hold_next  = hold_reg;
      px_next    = px_reg;
      py_next    = py_reg;
      case (state_reg)
         HOLD: begin
            if (tick) begin
               if (hold_reg == HOLD_W'(HOLD_TICKS - 1)) begin
                  state_next = RUN;
                  hold_next  = '0;
               end else begin
                  hold_next = hold_reg + 1'b1;
               end
            end
         end
         RUN: begin
            if (goal_any) begin
               state_next = GOAL;
            end else if (step_en) begin
               px_next = step_axis(px_reg, prod_x, size, x_hi);
               py_next = step_axis(py_reg, prod_y, size, y_hi);
            end
         end
         GOAL: begin
            state_next = HOLD;
            hold_next  = '0;
            px_next    = {13'(FIELD_W / 2), 8'h00};
            py_next    = {13'(FIELD_H / 2), 8'h00};
         end
         default: state_next = HOLD;
      endcase
   end

`ifdef BALL_SPEEDUP_EN
   logic [12:0] speed_reg;
   logic [1:0]  last_sign_reg;   // {negative, positive} x-sign seen on the previous stepping tick
   logic        cx_neg, cx_pos, flip;

   assign cx_neg    = (cx < 0);
   assign cx_pos    = (cx > 0);
   assign flip      = (cx_neg && last_sign_reg[0]) || (cx_pos && last_sign_reg[1]);
   assign cur_speed = speed_reg;

   always_ff @(posedge clk) begin
      if (rst || state_reg == GOAL) begin
         speed_reg     <= move_speed;
         last_sign_reg <= 2'b00;
      end else if (step_en) begin
         last_sign_reg <= {cx_neg, cx_pos};
         if (flip && speed_reg < 13'(SPEED_MAX))
            speed_reg <= speed_reg + 1'b1;
      end
   end
`else
   assign cur_speed = move_speed;
`endif

endmodule
